axi4_stream_frag_hdr_ins: RTL

AXI4_STREAM_FRAG_HDR_INS -- requirements
Module: axi4_stream_frag_hdr_ins

---
 rtl/axi4_stream_frag_hdr_ins_if.sv | 24 ++
 rtl/axi4_stream_frag_hdr_ins.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/axi4_stream_frag_hdr_ins_if.sv
// AXI4-Stream bundle shared by the fragment header inserter and its bench.
//   master : drives tdata/tkeep/tstrb/tlast/tid/tdest/tuser/tvalid, samples tready
//   slave  : samples the payload and tvalid, drives tready
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid,
                  input  tready);
  modport slave  (input  tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid,
                  output tready);
endinterface

// File: rtl/axi4_stream_frag_hdr_ins.sv
// Fragment header inserter: prefixes every AXI4-Stream fragment with one
// header word {HDR_MAGIC in [31:16], sequence number in [SEQ_WIDTH-1:0]}.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   seq_clr_i      : pulse, clears the fragment sequence number
//   pkt_i          : incoming fragments (tlast ends a fragment)
//   pkt_o          : header-prefixed fragments, driven straight from one register
//   frag_cnt_o     : count of fragments whose last beat left pkt_o (wraps)
module axi4_stream_frag_hdr_ins #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ID_WIDTH   = 1,
  parameter int          DEST_WIDTH = 1,
  parameter int          USER_WIDTH = 1,
  parameter int          SEQ_WIDTH  = 16,
  parameter logic [15:0] HDR_MAGIC  = 16'hF5A6
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         seq_clr_i,
  axi4_stream_if.slave  pkt_i,
  axi4_stream_if.master pkt_o,
  output logic [31:0]  frag_cnt_o
);
  localparam int KW = DATA_WIDTH / 8;

  typedef enum logic {IDLE, DATA} state_e;

  state_e                state_q, state_d;
  logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
  logic                  clr_pend_q, clr_pend_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KW-1:0]         tkeep_q, tkeep_d, tstrb_q, tstrb_d;
  logic                  tlast_q, tlast_d, tvalid_q, tvalid_d;
  logic [ID_WIDTH-1:0]   tid_q, tid_d;
  logic [DEST_WIDTH-1:0] tdest_q, tdest_d;
  logic [USER_WIDTH-1:0] tuser_q, tuser_d;
  logic [31:0]           frag_cnt_q;
  logic                  out_free;
  logic [DATA_WIDTH-1:0] hdr_word;

  assign out_free     = !tvalid_q || pkt_o.tready;
  assign pkt_i.tready = (state_q == DATA) && out_free;

  always_comb begin
    hdr_word                  = '0;
    hdr_word[31:16]           = HDR_MAGIC;
    hdr_word[SEQ_WIDTH-1:0]   = seq_q;
  end

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    clr_pend_d = clr_pend_q;
    tdata_d    = tdata_q;
    tkeep_d    = tkeep_q;
    tstrb_d    = tstrb_q;
    tlast_d    = tlast_q;
    tid_d      = tid_q;
    tdest_d    = tdest_q;
    tuser_d    = tuser_q;
    tvalid_d   = tvalid_q && !pkt_o.tready;
    case (state_q)
      IDLE: begin
        if (pkt_i.tvalid && out_free) begin
          // Header takes sideband from the waiting first beat (not yet accepted).
          tdata_d  = hdr_word;
          tkeep_d  = '1;
          tstrb_d  = '1;
          tlast_d  = 1'b0;
          tid_d    = pkt_i.tid;
          tdest_d  = pkt_i.tdest;
          tuser_d  = pkt_i.tuser;
          tvalid_d = 1'b1;
          state_d  = DATA;
          // A clear landing with the header only affects the next fragment.
          clr_pend_d = seq_clr_i;
        end else if (seq_clr_i) begin
          seq_d = '0;
        end
      end
      DATA: begin
        if (seq_clr_i) clr_pend_d = 1'b1;
        if (pkt_i.tvalid && out_free) begin
          tdata_d  = pkt_i.tdata;
          tkeep_d  = pkt_i.tkeep;
          tstrb_d  = pkt_i.tstrb;
          tlast_d  = pkt_i.tlast;
          tid_d    = pkt_i.tid;
          tdest_d  = pkt_i.tdest;
          tuser_d  = pkt_i.tuser;
          tvalid_d = 1'b1;
          if (pkt_i.tlast) begin
            seq_d      = (clr_pend_q || seq_clr_i) ? '0 : SEQ_WIDTH'(seq_q + 1'b1);
            clr_pend_d = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      seq_q      <= '0;
      clr_pend_q <= 1'b0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tstrb_q    <= '0;
      tlast_q    <= 1'b0;
      tid_q      <= '0;
      tdest_q    <= '0;
      tuser_q    <= '0;
      tvalid_q   <= 1'b0;
      frag_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      clr_pend_q <= clr_pend_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      tstrb_q    <= tstrb_d;
      tlast_q    <= tlast_d;
      tid_q      <= tid_d;
      tdest_q    <= tdest_d;
      tuser_q    <= tuser_d;
      tvalid_q   <= tvalid_d;
      if (tvalid_q && pkt_o.tready && tlast_q) frag_cnt_q <= frag_cnt_q + 32'd1;
    end
  end

  assign pkt_o.tdata  = tdata_q;
  assign pkt_o.tkeep  = tkeep_q;
  assign pkt_o.tstrb  = tstrb_q;
  assign pkt_o.tlast  = tlast_q;
  assign pkt_o.tid    = tid_q;
  assign pkt_o.tdest  = tdest_q;
  assign pkt_o.tuser  = tuser_q;
  assign pkt_o.tvalid = tvalid_q;
  assign frag_cnt_o   = frag_cnt_q;
endmodule
